// File: rtl/adder_selftest_checker.sv
// Adder self-test checker: walks every operand pair through an adder under
// test, holds each pair for a settle dwell, then compares the adder's
// {carry, sum} against a built-in golden sum. Reports done/pass, the number
// of mismatching vectors and the first failing vector.
module adder_selftest_checker #(
    parameter int WIDTH = 1,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_carry,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int VW = 2 * WIDTH;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t           state_q;
    logic [VW-1:0]    vec_q;
    logic [DW-1:0]    dwell_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             busy_q, done_q, pass_q;
    logic [VW:0]      err_q;
    logic             fail_valid_q;
    logic [WIDTH-1:0] fail_a_q, fail_b_q;

    logic [WIDTH:0]   exp_d;
    logic [WIDTH:0]   act_d;
    logic             mismatch_d;
    logic [VW:0]      err_d;
    logic [VW-1:0]    vec_inc_d;

    // Golden sum of the currently applied vector versus the adder's response.
    always_comb begin
        exp_d      = {1'b0, a_q} + {1'b0, b_q};
        act_d      = {dut_carry, dut_sum};
        mismatch_d = (exp_d != act_d);
        err_d      = err_q + {{VW{1'b0}}, mismatch_d};
        vec_inc_d  = vec_q + VW'(1);
    end

    // Run sequencer: apply vector, dwell, sample and score, advance or finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            dwell_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= APPLY;
                        vec_q        <= '0;
                        dwell_q      <= '0;
                        a_q          <= '0;
                        b_q          <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
                    end
                end
                APPLY: begin
                    dwell_q <= dwell_q + DW'(1);
                    if (dwell_q == DWELL_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_q <= err_d;
                    if (mismatch_d && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_a_q     <= a_q;
                        fail_b_q     <= b_q;
                    end
                    if (&vec_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        a_q     <= '0;
                        b_q     <= '0;
                    end else begin
                        state_q <= APPLY;
                        vec_q   <= vec_inc_d;
                        dwell_q <= '0;
                        a_q     <= vec_inc_d[VW-1:WIDTH];
                        b_q     <= vec_inc_d[WIDTH-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule
